// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/response bundle between pipeline and muldiv sequencer
interface muldiv_sequencer_if #(
    parameter int N = 32
);
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    // pipeline side issues requests and kills, sequencer side answers
    modport master (output start, op, a, b, flush, input busy, done, result);
    modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide sequencer
module muldiv_sequencer #(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_op;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [CW-1:0]  r_count;
    // multiply: {product high, product low / multiplier}; divide: {remainder, quotient / dividend}
    logic [2*N-1:0] r_prod;
    logic [N-1:0]   r_opb;
    logic [N-1:0]   r_result;

    logic           w_busy;
    logic           w_done;
    logic           w_accept;
    logic           w_sign_a;
    logic           w_sign_b;
    logic           w_sa;
    logic           w_sb;
    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic           w_b_zero;
    logic           w_ovf;
    logic           w_special;
    logic [N-1:0]   w_special_res;
    logic [N:0]     w_mul_sum;
    logic [N:0]     w_div_shift;
    logic [N-1:0]   w_div_diff;
    logic           w_div_ge;
    logic [2*N-1:0] w_step;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;
    logic [N-1:0]   w_fix_res;

    // request decode: operand signedness, magnitudes and the no-iteration cases
    always_comb begin
        w_sign_a = 1'b0;
        w_sign_b = 1'b0;
        case (bus.op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sign_a = 1'b1;
                w_sign_b = 1'b1;
            end
            3'b010:  w_sign_a = 1'b1;
            default: ;
        endcase
        w_sa          = w_sign_a & bus.a[N-1];
        w_sb          = w_sign_b & bus.b[N-1];
        w_mag_a       = w_sa ? -bus.a : bus.a;
        w_mag_b       = w_sb ? -bus.b : bus.b;
        w_b_zero      = (bus.b == '0);
        w_ovf         = bus.op[2] && !bus.op[0] && (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == '1);
        w_special     = bus.op[2] && (w_b_zero || w_ovf);
        // REM/REMU have op[1] set; DIV/DIVU do not
        if (w_b_zero)
            w_special_res = bus.op[1] ? bus.a : '1;
        else
            w_special_res = bus.op[1] ? '0 : bus.a;
    end

    // one iteration of shift-add multiply or restoring divide, plus the final sign fix
    always_comb begin
        w_mul_sum   = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_opb} : '0);
        w_div_shift = {r_prod[2*N-1:N], r_prod[N-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opb});
        // only used when the subtract fits, so the low N bits are exact
        w_div_diff  = w_div_shift[N-1:0] - r_opb;
        if (r_op[2])
            w_step = {(w_div_ge ? w_div_diff : w_div_shift[N-1:0]), r_prod[N-2:0], w_div_ge};
        else
            w_step = {w_mul_sum, r_prod[N-1:1]};
        w_prod_fix = r_neg_q ? -r_prod : r_prod;
        w_quo_fix  = r_neg_q ? -r_prod[N-1:0] : r_prod[N-1:0];
        w_rem_fix  = r_neg_r ? -r_prod[2*N-1:N] : r_prod[2*N-1:N];
        case (r_op)
            3'b000:                 w_fix_res = w_prod_fix[N-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*N-1:N];
            3'b100, 3'b101:         w_fix_res = w_quo_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    // next-state and handshake outputs; flush beats every forward transition
    always_comb begin
        w_next   = r_state;
        w_busy   = (r_state != IDLE);
        w_done   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_accept = 1'b1;
                    w_next   = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.flush)
                    w_next = IDLE;
                else if (r_count == LAST)
                    w_next = FIX;
            end
            FIX:  w_next = bus.flush ? IDLE : DONE;
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // datapath: capture on accept, iterate in CALC, commit the result in FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_count  <= '0;
            r_prod   <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.op;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_prod  <= {{N{1'b0}}, w_mag_a};
                        r_opb   <= w_mag_b;
                        r_count <= '0;
                        if (w_special)
                            r_result <= w_special_res;
                    end
                end
                CALC: begin
                    r_prod  <= w_step;
                    r_count <= r_count + 1'b1;
                end
                FIX: begin
                    if (!bus.flush)
                        r_result <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_sequencer_if #(.N(N)) bus();

    muldiv_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'b0, b});
        longint          p;
        longint unsigned up;
        int              ia = int'(a);
        int              ib = int'(b);
        logic [31:0]     r;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(ia / ib);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(ia % ib);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // issue one operation, scramble the inputs while it runs, check result and latency
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        bit          busy_ok;
        exp     = ref_model(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : N + 2;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        lat       = 0;
        busy_ok   = 1'b1;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.op    = 3'($urandom);
            bus.a     = $urandom;
            bus.b     = $urandom;
            lat++;
            if (!bus.busy) busy_ok = 1'b0;
        end while (!bus.done && lat < 100);
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] ha;
        logic [31:0] hb;
        int          seen;
        int          gap;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
        run_op(3'd1, 32'd7, 32'hFFFF_FFFD, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, "div");
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, "rem");
        run_op(3'd5, 32'd20, 32'd3, "divu");
        run_op(3'd7, 32'd20, 32'd3, "remu");
        run_op(3'd4, 32'd5, 32'd0, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), "rand");

        // flush mid-operation: back to idle, no done, result untouched
        prev = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hFFFF_FFEC; bus.b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("flush_no_done", seen, 32'd0);
        check("flush_result", bus.result, prev);

        // flush together with start in idle blocks acceptance
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", {31'b0, bus.busy}, 32'd0);

        // reset mid-operation
        run_op(3'd5, 32'd100, 32'd7, "pre_rst");
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd1000; bus.b = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("rst_no_done", seen, 32'd0);

        // start held high: operations chain with exactly one idle cycle between them
        ha = $urandom;
        hb = $urandom;
        bus.op = 3'd3; bus.a = ha; bus.b = hb; bus.start = 1'b1;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.done && gap < 100);
        check("held_first_result", bus.result, ref_model(3'd3, ha, hb));
        check("held_first_latency", gap, N + 2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("held_idle_gap", {31'b0, bus.busy}, 32'd0);
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                if (gap == 1) check("held_reaccept", {31'b0, bus.busy}, 32'd1);
            end while (!bus.done && gap < 100);
            check("held_spacing", gap, N + 2);
            check("held_result", bus.result, ref_model(3'd3, ha, hb));
        end
        bus.start = 1'b0;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (bus.busy && gap < 100);
        check("held_drain", {31'b0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
